// File: rtl/step_pulse_gen.sv
// Step/direction command generator: turns a valid/ready move command into registered
// rotate_pulse/direction/module_enable with direction setup, fixed pulse width and enable hold-off.
module step_pulse_gen #(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 16,
  parameter int SETUP_CYC = 27,
  parameter int HIGH_CYC  = 27,
  parameter int HOLD_CYC  = 2700
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             rotate_pulse,
  output logic             direction,
  output logic             module_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam int PH_MAX_A = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int PH_MAX   = (PH_MAX_A > HOLD_CYC) ? PH_MAX_A : HOLD_CYC;
  localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  SETUP_LD = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]  HIGH_LD  = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0]  HOLD_LD  = PH_W'(HOLD_CYC - 1);
  localparam logic [PER_W-1:0] HIGH_P   = PER_W'(HIGH_CYC);
  localparam logic [PER_W-1:0] MIN_P    = PER_W'(HIGH_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PER_W-1:0] low_len_q, low_len_d;
  logic             abort_pend_q, abort_pend_d;
  logic             dir_d, en_d, done_d, rot_d, busy_d, ready_d;
  logic [CNT_W-1:0] steps_d;

  logic             accept;
  logic [PER_W-1:0] eff_period;

  assign accept     = cmd_valid & cmd_ready;
  assign eff_period = (cmd_period > HIGH_P) ? cmd_period : MIN_P;

  always_comb begin
    state_d      = state_q;
    ph_cnt_d     = ph_cnt_q;
    per_cnt_d    = per_cnt_q;
    low_len_d    = low_len_q;
    abort_pend_d = abort_pend_q;
    dir_d        = direction;
    en_d         = module_enable;
    steps_d      = steps_left;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept && (cmd_steps != '0)) begin
          state_d      = S_SETUP;
          ph_cnt_d     = SETUP_LD;
          low_len_d    = eff_period - HIGH_P;
          abort_pend_d = 1'b0;
          dir_d        = cmd_dir;
          en_d         = 1'b1;
          steps_d      = cmd_steps;
        end else begin
          // A zero-length command only reports completion; a running hold-off keeps counting.
          done_d = accept;
          if (state_q == S_HOLD) begin
            if (ph_cnt_q == '0) begin
              state_d = S_IDLE;
              en_d    = 1'b0;
            end else begin
              ph_cnt_d = ph_cnt_q - PH_W'(1);
            end
          end
        end
      end

      S_SETUP: begin
        if (abort) begin
          state_d  = S_HOLD;
          ph_cnt_d = HOLD_LD;
          done_d   = 1'b1;
        end else if (ph_cnt_q == '0) begin
          state_d  = S_HIGH;
          ph_cnt_d = HIGH_LD;
          steps_d  = steps_left - CNT_W'(1);
        end else begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
        end
      end

      S_HIGH: begin
        // An abort here is remembered so the pulse still gets its full width.
        if (abort) abort_pend_d = 1'b1;
        if (ph_cnt_q == '0) begin
          if (abort || abort_pend_q) begin
            state_d  = S_HOLD;
            ph_cnt_d = HOLD_LD;
            done_d   = 1'b1;
          end else begin
            state_d   = S_LOW;
            per_cnt_d = low_len_q - PER_W'(1);
          end
        end else begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
        end
      end

      S_LOW: begin
        if (abort || ((per_cnt_q == '0) && (steps_left == '0))) begin
          state_d  = S_HOLD;
          ph_cnt_d = HOLD_LD;
          done_d   = 1'b1;
        end else if (per_cnt_q == '0) begin
          state_d  = S_HIGH;
          ph_cnt_d = HIGH_LD;
          steps_d  = steps_left - CNT_W'(1);
        end else begin
          per_cnt_d = per_cnt_q - PER_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase

    rot_d   = (state_d == S_HIGH);
    busy_d  = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
    ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
  end

  // Every output is a flop so rotate_pulse cannot glitch into the downstream phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ph_cnt_q      <= '0;
      per_cnt_q     <= '0;
      low_len_q     <= '0;
      abort_pend_q  <= 1'b0;
      rotate_pulse  <= 1'b0;
      direction     <= 1'b0;
      module_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cmd_ready     <= 1'b0;
      steps_left    <= '0;
    end else begin
      state_q       <= state_d;
      ph_cnt_q      <= ph_cnt_d;
      per_cnt_q     <= per_cnt_d;
      low_len_q     <= low_len_d;
      abort_pend_q  <= abort_pend_d;
      rotate_pulse  <= rot_d;
      direction     <= dir_d;
      module_enable <= en_d;
      busy          <= busy_d;
      done          <= done_d;
      cmd_ready     <= ready_d;
      steps_left    <= steps_d;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with SETUP_CYC=4, HIGH_CYC=3, HOLD_CYC=10; samples on the falling edge.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        rotate_pulse, direction, module_enable, busy, done;
  logic [15:0] steps_left;

  int checks = 0;
  int failures = 0;

  step_pulse_gen #(
    .CNT_W(16), .PER_W(16), .SETUP_CYC(4), .HIGH_CYC(3), .HOLD_CYC(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period), .abort(abort),
    .rotate_pulse(rotate_pulse), .direction(direction), .module_enable(module_enable),
    .busy(busy), .done(done), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  // Offers one command for exactly one rising edge; returns 1ns after that edge (edge k).
  task automatic issue(input logic [15:0] steps, input logic dir, input logic [15:0] period);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_steps  = steps;
    cmd_dir    = dir;
    cmd_period = period;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rotate_pulse, direction, module_enable, busy, done, cmd_ready} !== 6'b0 || steps_left !== 16'd0) begin
      failures++;
      $display("FAIL reset_vals: rot=%b dir=%b en=%b busy=%b done=%b rdy=%b left=%0d required all 0",
               rotate_pulse, direction, module_enable, busy, done, cmd_ready, steps_left);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rdy=%b busy=%b required rdy=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_normal;
    logic e_rot, e_en, e_busy, e_done;
    logic [15:0] e_left;
    issue(16'd3, 1'b1, 16'd8);
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      e_rot  = (i >= 4 && i <= 6) || (i >= 12 && i <= 14) || (i >= 20 && i <= 22);
      e_done = (i == 28);
      e_busy = (i < 28);
      e_en   = (i < 38);
      e_left = (i < 4) ? 16'd3 : (i < 12) ? 16'd2 : (i < 20) ? 16'd1 : 16'd0;
      checks++;
      if (rotate_pulse !== e_rot || done !== e_done || busy !== e_busy ||
          module_enable !== e_en || steps_left !== e_left || direction !== 1'b1) begin
        failures++;
        $display("FAIL normal_move k+%0d: rot=%b done=%b busy=%b en=%b left=%0d dir=%b required %b %b %b %b %0d 1",
                 i, rotate_pulse, done, busy, module_enable, steps_left, direction,
                 e_rot, e_done, e_busy, e_en, e_left);
      end
    end
  endtask

  task automatic test_period_clamp;
    logic e_rot, e_en, e_done;
    issue(16'd2, 1'b0, 16'd2);
    for (int i = 0; i <= 25; i++) begin
      @(negedge clk);
      e_rot  = (i >= 4 && i <= 6) || (i >= 8 && i <= 10);
      e_done = (i == 12);
      e_en   = (i < 22);
      checks++;
      if (rotate_pulse !== e_rot || done !== e_done || module_enable !== e_en) begin
        failures++;
        $display("FAIL period_clamp k+%0d: rot=%b done=%b en=%b required %b %b %b",
                 i, rotate_pulse, done, module_enable, e_rot, e_done, e_en);
      end
    end
  endtask

  task automatic test_zero_steps;
    issue(16'd0, 1'b1, 16'd8);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== (i == 0) || rotate_pulse !== 1'b0 || module_enable !== 1'b0 ||
          busy !== 1'b0 || cmd_ready !== 1'b1 || steps_left !== 16'd0 || direction !== 1'b0) begin
        failures++;
        $display("FAIL zero_steps k+%0d: done=%b rot=%b en=%b busy=%b rdy=%b left=%0d dir=%b required done=%b others idle",
                 i, done, rotate_pulse, module_enable, busy, cmd_ready, steps_left, direction, (i == 0));
      end
    end
  endtask

  task automatic test_abort;
    logic e_rot, e_en, e_busy, e_done;
    logic [15:0] e_left;
    issue(16'd5, 1'b1, 16'd8);
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      e_rot  = (i >= 4 && i <= 6) || (i >= 12 && i <= 14);
      e_done = (i == 15);
      e_busy = (i < 15);
      e_en   = (i < 25);
      e_left = (i < 4) ? 16'd5 : (i < 12) ? 16'd4 : 16'd3;
      checks++;
      if (rotate_pulse !== e_rot || done !== e_done || busy !== e_busy ||
          module_enable !== e_en || steps_left !== e_left) begin
        failures++;
        $display("FAIL abort_high k+%0d: rot=%b done=%b busy=%b en=%b left=%0d required %b %b %b %b %0d",
                 i, rotate_pulse, done, busy, module_enable, steps_left,
                 e_rot, e_done, e_busy, e_en, e_left);
      end
      if (i == 13) abort = 1'b1;
      if (i == 14) abort = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic e_rot, e_en, e_dir, e_done, e_rdy;
    issue(16'd1, 1'b0, 16'd8);
    for (int i = 0; i <= 42; i++) begin
      @(negedge clk);
      e_rot  = (i >= 4 && i <= 6) || (i >= 21 && i <= 23);
      e_done = (i == 12) || (i == 29);
      e_en   = (i < 39);
      e_dir  = (i >= 17);
      e_rdy  = (i >= 12 && i < 17) || (i >= 29);
      checks++;
      if (rotate_pulse !== e_rot || done !== e_done || module_enable !== e_en ||
          direction !== e_dir || cmd_ready !== e_rdy) begin
        failures++;
        $display("FAIL back_to_back k+%0d: rot=%b done=%b en=%b dir=%b rdy=%b required %b %b %b %b %b",
                 i, rotate_pulse, done, module_enable, direction, cmd_ready,
                 e_rot, e_done, e_en, e_dir, e_rdy);
      end
      cmd_valid = (i == 16);
      cmd_steps = 16'd1;
      cmd_dir   = 1'b1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_move;
    issue(16'd4, 1'b1, 16'd8);
    repeat (6) @(negedge clk);
    checks++;
    if (rotate_pulse !== 1'b1 || module_enable !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: rot=%b en=%b required 1 1", rotate_pulse, module_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rotate_pulse !== 1'b0 || module_enable !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: rot=%b en=%b busy=%b required 0 0 0", rotate_pulse, module_enable, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || rotate_pulse !== 1'b0 ||
          module_enable !== 1'b0 || steps_left !== 16'd0) begin
        failures++;
        $display("FAIL rst_after +%0d: done=%b rdy=%b busy=%b rot=%b en=%b left=%0d required 0 1 0 0 0 0",
                 i, done, cmd_ready, busy, rotate_pulse, module_enable, steps_left);
      end
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_period_clamp;
    test_zero_steps;
    test_abort;
    test_back_to_back;
    test_reset_mid_move;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
